fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16: rd_clk cycles per serial bit period; legal range >= 2.
REQ-002 SHALL provide port rd_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port tx_en  input  1  permit starting new frames.
REQ-005 SHALL provide port fifo_empty  input  1  FIFO empty flag from the read side.
REQ-006 SHALL provide port fifo_data  input  8  FIFO read data, registered by the FIFO on the rd_clk edge that samples fifo_rd.
REQ-007 SHALL provide port fifo_rd  output  1  FIFO read strobe, one cycle per byte.
REQ-008 SHALL provide port tx  output  1  serial line, idle high.
REQ-009 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, FETCH, START, DATA, PARITY (macro only), STOP.
REQ-011 IDLE: if tx_en=1 and fifo_empty=0, SHALL assert fifo_rd for exactly that cycle and go to FETCH; else stay, fifo_rd=0.
REQ-012 FETCH: SHALL last one cycle, load fifo_data into the 8-bit shift register at its end, then go to START.
REQ-013 START, each DATA bit, PARITY, STOP: each SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter reset on each state/bit change.
REQ-014 tx SHALL be 0 in START, shift register bit 0 in DATA (LSB first, shift right per bit), 1 in STOP, IDLE, FETCH.
REQ-015 DATA SHALL use a 3-bit bit counter; on bit 7 expiry go to PARITY (macro) or STOP; counter wraps 7->0.
REQ-016 STOP expiry SHALL return to IDLE; minimum gap between frames is therefore 2 high cycles (IDLE + FETCH).
REQ-017 fifo_rd SHALL never assert outside IDLE and never while fifo_empty=1.
REQ-018 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->FETCH transition.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-020 Baud counter width SHALL be $clog2(CLKS_PER_BIT); terminal count CLKS_PER_BIT-1.

Reset
REQ-021 On reset=1 at a rising edge: state=IDLE, tx=1, fifo_rd=0, busy=0, counters and shift register 0.
REQ-022 Reset mid-frame SHALL drop the byte in flight; tx SHALL be 1 from the following cycle; no fifo_rd in the reset cycle.

Configuration
REQ-023 Macro FIFO_UART_TX_PARITY_EN defined: SHALL insert PARITY state after DATA driving even parity (XOR of the 8 data bits).
REQ-024 Macro undefined: SHALL omit PARITY state and logic entirely; DATA goes directly to STOP.

Structure
REQ-025 Package fifo_uart_pkg SHALL hold the state enum typedef, default CLKS_PER_BIT constant, and data width constant (8).
REQ-026 Baud counter SHALL be sub-module uart_baud_gen (inputs clear, enable; output tick at terminal count).

Verification (CLKS_PER_BIT=4)
REQ-027 Reset held 3 cycles -> tx=1, fifo_rd=0, busy=0 throughout and after release with fifo_empty=1.
REQ-028 fifo_empty=0, fifo_data=8'hA5 after rd -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles, first 0 two cycles after fifo_rd.
REQ-029 Two bytes 8'h00 then 8'hFF queued -> exactly two fifo_rd pulses; frames separated by exactly 2 tx-high cycles.
REQ-030 tx_en dropped during DATA of byte 8'h3C -> frame completes intact; no fifo_rd until tx_en returns high.
REQ-031 reset asserted in DATA bit 3 -> next cycle tx=1, busy=0; no partial stop or extra fifo_rd.
REQ-032 Macro defined, byte 8'h07 -> PARITY bit 1 for 4 cycles before stop; byte 8'h03 -> PARITY bit 0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state enum.
package fifo_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial line and status, grouped for the UART transmitter.
// master = FIFO/host side, slave = transmitter.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              tx_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              tx;
  logic              busy;

  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy
  );

  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy
  );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts while enabled, ticks on the last cycle of each period.
// Zero latency tick (combinational from count); clear has priority over enable.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter; first start bit two cycles after fifo_rd, one frame at a time.
// tx_en only gates new frames; FIFO_UART_TX_PARITY_EN inserts an even-parity bit before stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic           rd_clk,
  input  logic           reset,
  fifo_uart_tx_if.slave  bus
);

  uart_state_e       state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              tx_q;
  logic              busy_q;
  logic              start;
  logic              baud_clear;
  logic              baud_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  // fifo_rd must land in the IDLE cycle itself so the FIFO's registered data is ready in FETCH.
  assign start       = (state == ST_IDLE) && bus.tx_en && !bus.fifo_empty;
  assign bus.fifo_rd = start && !reset;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign baud_clear  = (state == ST_IDLE) || (state == ST_FETCH);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (rd_clk),
    .reset  (reset),
    .clear  (baud_clear),
    .enable (!baud_clear),
    .tick   (baud_tick)
  );

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            busy_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          shreg    <= bus.fifo_data;
          bit_cnt  <= '0;
          tx_q     <= 1'b0;
          state    <= ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^bus.fifo_data;
`endif
        end
        ST_START: begin
          if (baud_tick) begin
            tx_q  <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q  <= parity_q;
              state <= ST_PARITY;
`else
              tx_q  <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              tx_q <= shreg[1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            tx_q  <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
